// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Groups the signals that connect the branch resolve unit to
//               fetch, the predictor and the execute stage.
//               The master modport is the environment side.
//               The slave modport is the resolve unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if;
  // Pipeline flush
  logic        iFLUSH;

  // Predictions consumed by fetch
  logic        iPRED_STB;
  logic [31:0] iPRED_INST_ADDR;
  logic        iPRED_BRANCH;
  logic [31:0] iPRED_ADDR;
  logic        oPRED_FULL;

  // Resolved outcomes from execute
  logic        iEXE_STB;
  logic        iEXE_IS_BRANCH;
  logic        iEXE_TAKEN;
  logic [31:0] iEXE_TARGET;

  // Predictor update port
  logic        oJUMP_STB;
  logic        oJUMP_VALID;
  logic [31:0] oJUMP_ADDR;
  logic [31:0] oJUMP_INST_ADDR;

  // Redirect handshake towards fetch
  logic        oMISS_STB;
  logic [31:0] oMISS_ADDR;
  logic        iMISS_ACK;
  logic [15:0] oMISS_COUNT;

  modport master (
    output iFLUSH, iPRED_STB, iPRED_INST_ADDR, iPRED_BRANCH, iPRED_ADDR,
    output iEXE_STB, iEXE_IS_BRANCH, iEXE_TAKEN, iEXE_TARGET, iMISS_ACK,
    input  oPRED_FULL, oJUMP_STB, oJUMP_VALID, oJUMP_ADDR, oJUMP_INST_ADDR,
    input  oMISS_STB, oMISS_ADDR, oMISS_COUNT
  );

  modport slave (
    input  iFLUSH, iPRED_STB, iPRED_INST_ADDR, iPRED_BRANCH, iPRED_ADDR,
    input  iEXE_STB, iEXE_IS_BRANCH, iEXE_TAKEN, iEXE_TARGET, iMISS_ACK,
    output oPRED_FULL, oJUMP_STB, oJUMP_VALID, oJUMP_ADDR, oJUMP_INST_ADDR,
    output oMISS_STB, oMISS_ADDR, oMISS_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Queues the predictions fetch consumed and checks each one
//               against the execute-stage outcome. It updates the predictor
//               and raises a handshaked redirect on a mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int P_DEPTH   = 8,
  parameter int P_DEPTH_N = 3
) (
  input  wire logic            iCLOCK,
  input  wire logic            inRESET,
  branch_resolve_unit_if.slave bus
);

  localparam logic [P_DEPTH_N:0] C_FULL = (P_DEPTH_N + 1)'(P_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Prediction queue storage; only the pointers and count need a reset
  logic [31:0] q_inst [P_DEPTH];
  logic        q_br   [P_DEPTH];
  logic [31:0] q_tgt  [P_DEPTH];

  logic [P_DEPTH_N-1:0] rd_ptr;
  logic [P_DEPTH_N-1:0] wr_ptr;
  logic [P_DEPTH_N:0]   count;

  logic        jump_stb;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic [31:0] jump_inst_addr;
  logic        miss_stb;
  logic [31:0] miss_addr;
  logic [15:0] miss_count;

  logic        full;
  logic        active;
  logic        push_ok;
  logic        pop_ok;
  logic [31:0] head_inst;
  logic        head_br;
  logic [31:0] head_tgt;
  logic        miss_cond;
  logic        miss;
  logic        jump_fire;
  logic [31:0] correct_addr;

  // Queue status, resolution decision and corrected fetch address
  always_comb begin
    full      = (count == C_FULL);
    // Wrong-path traffic is ignored while recovering; a flush wins over all
    active    = (state == ST_IDLE) && !bus.iFLUSH;
    // Full is sampled before the pop, so a push into a full queue is lost
    push_ok   = active && bus.iPRED_STB && !full;
    pop_ok    = active && bus.iEXE_STB && (count != '0);
    head_inst = q_inst[rd_ptr];
    head_br   = q_br[rd_ptr];
    head_tgt  = q_tgt[rd_ptr];
    if (bus.iEXE_IS_BRANCH) begin
      miss_cond = (bus.iEXE_TAKEN != head_br) ||
                  (bus.iEXE_TAKEN && (bus.iEXE_TARGET != head_tgt));
    end else begin
      // A non-branch predicted taken means the predictor entry is aliased
      miss_cond = head_br;
    end
    miss      = pop_ok && miss_cond;
    jump_fire = pop_ok && (bus.iEXE_IS_BRANCH || head_br);
    if (bus.iEXE_IS_BRANCH && bus.iEXE_TAKEN) begin
      correct_addr = bus.iEXE_TARGET;
    end else begin
      correct_addr = head_inst + 32'd4;
    end
  end

  // Next-state logic for the recovery handshake
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (miss) state_next = ST_RECOVER;
      ST_RECOVER: if (bus.iMISS_ACK) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (bus.iFLUSH) state_next = ST_IDLE;
  end

  // State register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Queue entry write on an accepted push
  always_ff @(posedge iCLOCK) begin
    if (push_ok) begin
      q_inst[wr_ptr] <= bus.iPRED_INST_ADDR;
      q_br[wr_ptr]   <= bus.iPRED_BRANCH;
      q_tgt[wr_ptr]  <= bus.iPRED_ADDR;
    end
  end

  // Queue pointers and occupancy; a miss or flush discards every entry
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.iFLUSH || miss) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Predictor update outputs, one-cycle strobe after a resolution
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      jump_stb       <= 1'b0;
      jump_valid     <= 1'b0;
      jump_addr      <= '0;
      jump_inst_addr <= '0;
    end else begin
      jump_stb <= jump_fire;
      if (jump_fire) begin
        jump_valid     <= bus.iEXE_IS_BRANCH && bus.iEXE_TAKEN;
        jump_addr      <= bus.iEXE_TARGET;
        jump_inst_addr <= head_inst;
      end
    end
  end

  // Redirect request, held until fetch acknowledges it, and miss counter
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      miss_stb   <= 1'b0;
      miss_addr  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.iFLUSH) begin
        miss_stb <= 1'b0;
      end else if (miss) begin
        miss_stb  <= 1'b1;
        miss_addr <= correct_addr;
      end else if ((state == ST_RECOVER) && bus.iMISS_ACK) begin
        miss_stb <= 1'b0;
      end
      if (miss && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end

  assign bus.oPRED_FULL      = full;
  assign bus.oJUMP_STB       = jump_stb;
  assign bus.oJUMP_VALID     = jump_valid;
  assign bus.oJUMP_ADDR      = jump_addr;
  assign bus.oJUMP_INST_ADDR = jump_inst_addr;
  assign bus.oMISS_STB       = miss_stb;
  assign bus.oMISS_ADDR      = miss_addr;
  assign bus.oMISS_COUNT     = miss_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit. It uses a
//               vector table, directed corner sequences and random traffic
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_unit_if bif ();

  branch_resolve_unit #(.P_DEPTH(DEPTH), .P_DEPTH_N(3)) dut (
    .iCLOCK (clk),
    .inRESET(rst_n),
    .bus    (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: program-order queue plus redirect state
  typedef struct { logic [31:0] ia; logic br; logic [31:0] pa; } ent_t;
  ent_t        q[$];
  bit          m_rec;
  bit          m_mstb;
  logic [31:0] m_maddr;
  int          m_mcnt;
  bit          e_jstb, e_jvalid, e_jchk;
  logic [31:0] e_jaddr, e_jia;

  typedef struct {
    bit fl; bit ps; logic [31:0] pia; bit pbr; logic [31:0] pad;
    bit es; bit eib; bit etk; logic [31:0] etg; bit ack;
    bit x_full; bit x_jstb; bit x_jvalid; bit x_jchk; logic [31:0] x_jaddr; logic [31:0] x_jia;
    bit x_mstb; logic [31:0] x_maddr; logic [15:0] x_mcnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rec = 0; m_mstb = 0; m_maddr = '0; m_mcnt = 0;
    e_jstb = 0; e_jvalid = 0; e_jchk = 0; e_jaddr = '0; e_jia = '0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input bit fl, input bit ps, input logic [31:0] pia, input bit pbr,
                      input logic [31:0] pad, input bit es, input bit eib, input bit etk,
                      input logic [31:0] etg, input bit ack);
    ent_t h, n;
    bit was_full, miss;
    logic [31:0] corr;
    bif.iFLUSH = fl; bif.iPRED_STB = ps; bif.iPRED_INST_ADDR = pia;
    bif.iPRED_BRANCH = pbr; bif.iPRED_ADDR = pad; bif.iEXE_STB = es;
    bif.iEXE_IS_BRANCH = eib; bif.iEXE_TAKEN = etk; bif.iEXE_TARGET = etg;
    bif.iMISS_ACK = ack;
    e_jstb = 0;
    corr = '0;
    if (fl) begin
      q.delete(); m_rec = 0; m_mstb = 0;
    end else if (!m_rec) begin
      was_full = (q.size() == DEPTH);
      miss = 0;
      if (es && q.size() != 0) begin
        h = q.pop_front();
        if (eib) begin
          miss = (etk != h.br) || (etk && (etg != h.pa));
          e_jstb = 1; e_jvalid = etk; e_jaddr = etg; e_jchk = 1; e_jia = h.ia;
          corr = etk ? etg : h.ia + 32'd4;
        end else begin
          miss = h.br;
          corr = h.ia + 32'd4;
          if (h.br) begin e_jstb = 1; e_jvalid = 0; e_jchk = 0; e_jia = h.ia; end
        end
      end
      if (ps && !was_full) begin
        n.ia = pia; n.br = pbr; n.pa = pad;
        q.push_back(n);
      end
      if (miss) begin
        q.delete(); m_rec = 1; m_mstb = 1; m_maddr = corr;
        if (m_mcnt < 65535) m_mcnt++;
      end
    end else if (ack) begin
      m_rec = 0; m_mstb = 0;
    end
    @(posedge clk); #1;
    chk("full", bif.oPRED_FULL, q.size() == DEPTH);
    chk("jump_stb", bif.oJUMP_STB, e_jstb);
    if (e_jstb) begin
      chk("jump_valid", bif.oJUMP_VALID, e_jvalid);
      chk("jump_inst_addr", bif.oJUMP_INST_ADDR, e_jia);
      if (e_jchk) chk("jump_addr", bif.oJUMP_ADDR, e_jaddr);
    end
    chk("miss_stb", bif.oMISS_STB, m_mstb);
    if (m_mstb) chk("miss_addr", bif.oMISS_ADDR, m_maddr);
    chk("miss_count", bif.oMISS_COUNT, m_mcnt[15:0]);
  endtask

  task automatic idle(input bit ack);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
  endtask

  task automatic push(input logic [31:0] ia, input bit br, input logic [31:0] pa);
    step(0, 1, ia, br, pa, 0, 0, 0, 0, 0);
  endtask

  task automatic add(input bit fl, ps, input logic [31:0] pia, input bit pbr, input logic [31:0] pad,
                     input bit es, eib, etk, input logic [31:0] etg, input bit ack,
                     input bit xf, xj, xv, xc, input logic [31:0] xja, xjia,
                     input bit xm, input logic [31:0] xma, input logic [15:0] xmc);
    vec_t v;
    v.fl = fl; v.ps = ps; v.pia = pia; v.pbr = pbr; v.pad = pad;
    v.es = es; v.eib = eib; v.etk = etk; v.etg = etg; v.ack = ack;
    v.x_full = xf; v.x_jstb = xj; v.x_jvalid = xv; v.x_jchk = xc; v.x_jaddr = xja; v.x_jia = xjia;
    v.x_mstb = xm; v.x_maddr = xma; v.x_mcnt = xmc;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cnt_snap;
    rst_n = 1'b0;
    bif.iFLUSH = 0; bif.iPRED_STB = 0; bif.iPRED_INST_ADDR = 0; bif.iPRED_BRANCH = 0;
    bif.iPRED_ADDR = 0; bif.iEXE_STB = 0; bif.iEXE_IS_BRANCH = 0; bif.iEXE_TAKEN = 0;
    bif.iEXE_TARGET = 0; bif.iMISS_ACK = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_full", bif.oPRED_FULL, 0);
    chk("rst_jump_stb", bif.oJUMP_STB, 0);
    chk("rst_jump_valid", bif.oJUMP_VALID, 0);
    chk("rst_jump_addr", bif.oJUMP_ADDR, 0);
    chk("rst_jump_inst", bif.oJUMP_INST_ADDR, 0);
    chk("rst_miss_stb", bif.oMISS_STB, 0);
    chk("rst_miss_addr", bif.oMISS_ADDR, 0);
    chk("rst_miss_count", bif.oMISS_COUNT, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- vector table: correct taken, not-taken miss with held redirect,
    //      aliased non-branch with address wrap, ack in the resolving cycle
    add(0,1,32'h100,1,32'h200, 0,0,0,0,0,  0,0,0,0,0,0,                 0,0,0);
    add(0,0,0,0,0,             1,1,1,32'h200,0, 0,1,1,1,32'h200,32'h100, 0,0,0);
    add(0,0,0,0,0,             0,0,0,0,0,  0,0,0,0,0,0,                 0,0,0);
    add(0,1,32'h104,0,0,       0,0,0,0,0,  0,0,0,0,0,0,                 0,0,0);
    add(0,0,0,0,0,             1,1,1,32'h300,0, 0,1,1,1,32'h300,32'h104, 1,32'h300,1);
    add(0,1,32'h500,0,0,       0,0,0,0,0,  0,0,0,0,0,0,                 1,32'h300,1);
    add(0,1,32'h504,0,0,       0,0,0,0,0,  0,0,0,0,0,0,                 1,32'h300,1);
    add(0,0,0,0,0,             1,1,1,32'h300,0, 0,0,0,0,0,0,            1,32'h300,1);
    add(0,0,0,0,0,             0,0,0,0,1,  0,0,0,0,0,0,                 0,0,1);
    add(0,0,0,0,0,             1,1,1,32'h300,0, 0,0,0,0,0,0,            0,0,1);
    add(0,1,32'hFFFFFFFC,1,32'h40, 0,0,0,0,0, 0,0,0,0,0,0,              0,0,1);
    add(0,0,0,0,0,             1,0,0,0,0,  0,1,0,0,0,32'hFFFFFFFC,      1,32'h0,2);
    add(0,0,0,0,0,             0,0,0,0,1,  0,0,0,0,0,0,                 0,0,2);
    add(0,1,32'h10,1,32'h80,   0,0,0,0,0,  0,0,0,0,0,0,                 0,0,2);
    add(0,0,0,0,0,             1,1,0,32'h80,1, 0,1,0,1,32'h80,32'h10,   1,32'h14,3);
    add(0,0,0,0,0,             0,0,0,0,0,  0,0,0,0,0,0,                 1,32'h14,3);
    add(0,0,0,0,0,             0,0,0,0,1,  0,0,0,0,0,0,                 0,0,3);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.fl, v.ps, v.pia, v.pbr, v.pad, v.es, v.eib, v.etk, v.etg, v.ack);
      chk($sformatf("tbl%0d_full", i), bif.oPRED_FULL, v.x_full);
      chk($sformatf("tbl%0d_jstb", i), bif.oJUMP_STB, v.x_jstb);
      if (v.x_jstb) begin
        chk($sformatf("tbl%0d_jvalid", i), bif.oJUMP_VALID, v.x_jvalid);
        chk($sformatf("tbl%0d_jinst", i), bif.oJUMP_INST_ADDR, v.x_jia);
        if (v.x_jchk) chk($sformatf("tbl%0d_jaddr", i), bif.oJUMP_ADDR, v.x_jaddr);
      end
      chk($sformatf("tbl%0d_mstb", i), bif.oMISS_STB, v.x_mstb);
      if (v.x_mstb) chk($sformatf("tbl%0d_maddr", i), bif.oMISS_ADDR, v.x_maddr);
      chk($sformatf("tbl%0d_mcnt", i), bif.oMISS_COUNT, v.x_mcnt);
    end

    // ---- full queue: 8 pushes, dropped 9th, push+pop when full, drain order
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 4 * i, 1, 32'h2000 + i);
    chk("full_after8", bif.oPRED_FULL, 1);
    push(32'h9990, 1, 32'h9999);
    chk("full_after9", bif.oPRED_FULL, 1);
    step(0, 1, 32'h9994, 1, 32'h9999, 1, 1, 1, 32'h2000, 0);
    chk("full_pushpop_order", bif.oJUMP_INST_ADDR, 32'h1000);
    chk("full_pushpop_notfull", bif.oPRED_FULL, 0);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 1, 1, 1, 32'h2000 + i, 0);
      chk("drain_order", bif.oJUMP_INST_ADDR, 32'h1000 + 4 * i);
    end
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h2000, 0);
    chk("drain_empty_nostb", bif.oJUMP_STB, 0);

    // ---- simultaneous push and pop with three entries queued
    for (int i = 0; i < 3; i++) push(32'h3000 + 4 * i, 1, 32'h3100 + i);
    step(0, 1, 32'h300C, 1, 32'h3103, 1, 1, 1, 32'h3100, 0);
    chk("pp_oldest", bif.oJUMP_INST_ADDR, 32'h3000);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 1, 1, 32'h3100 + i, 0);
      chk("pp_order", bif.oJUMP_INST_ADDR, 32'h3000 + 4 * i);
    end
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h3100, 0);
    chk("pp_count3_nostb", bif.oJUMP_STB, 0);

    // ---- flush: with entries queued, with same-cycle resolution, and in RECOVER
    for (int i = 0; i < 5; i++) push(32'h4000 + 4 * i, 1, 32'h4100 + i);
    step(1, 0, 0, 0, 0, 1, 1, 1, 32'h4100, 0);
    chk("flush_discard_res", bif.oJUMP_STB, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h4100, 0);
    chk("flush_pop_empty", bif.oJUMP_STB, 0);
    push(32'h700, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h800, 0);
    chk("rec_miss_stb", bif.oMISS_STB, 1);
    cnt_snap = m_mcnt;
    for (int i = 0; i < 5; i++) push(32'h4000 + 4 * i, 1, 32'h4100 + i);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rec_flush_stb", bif.oMISS_STB, 0);
    chk("rec_flush_cnt", bif.oMISS_COUNT, cnt_snap[15:0]);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h4100, 0);
    chk("rec_flush_pop", bif.oJUMP_STB, 0);
    push(32'h900, 1, 32'hA00);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'hA00, 0);
    chk("post_flush_idle", bif.oJUMP_INST_ADDR, 32'h900);

    // ---- asynchronous reset in the middle of a redirect
    push(32'hB00, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'hC00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mstb", bif.oMISS_STB, 0);
    chk("async_rst_mcnt", bif.oMISS_COUNT, 0);
    chk("async_rst_jstb", bif.oJUMP_STB, 0);
    bif.iPRED_STB = 0; bif.iEXE_STB = 0; bif.iFLUSH = 0; bif.iMISS_ACK = 0;
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'hC00, 0);
    chk("after_rst_empty", bif.oJUMP_STB, 0);

    // ---- randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1) == 1),
           $urandom & 32'hFFFFFFFC,
           ($urandom_range(0, 1) == 1),
           32'h40 << $urandom_range(0, 3),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           32'h40 << $urandom_range(0, 3),
           ($urandom_range(0, 9) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
